// File: rtl/moddiv_pow2_pipe.sv
// moddiv_pow2_pipe
//
// Multi-lane pipelined modular halving unit: y = x * 2^-k mod q, with
// k = min(shift, MAX_SHIFT) when intt=1 and k = 0 otherwise. Stage s
// (1..MAX_SHIFT) halves its beat when s <= k and passes it through otherwise,
// so latency is always MAX_SHIFT cycles regardless of k. Works for any odd q.
//
// Ports:
//   clk        rising-edge clock
//   rstn       asynchronous active-low reset
//   q_load     load q_in into the modulus register (only while idle)
//   q_in       new odd modulus
//   in_valid   input beat valid
//   in_ready   input beat accepted when in_valid && in_ready
//   intt       1: divide by 2^shift, 0: pass through (sampled with the beat)
//   shift      requested shift k (sampled with the beat, saturates)
//   x          LANES coefficients, lane i = x[i*LOGQ +: LOGQ]
//   out_valid  output beat valid (last stage occupied)
//   out_ready  downstream accepts
//   y          LANES results, lane order preserved
//   busy       at least one stage holds a valid beat
module moddiv_pow2_pipe #(
    parameter int unsigned     LOGQ       = 64,
    parameter int unsigned     LANES      = 2,
    parameter int unsigned     MAX_SHIFT  = 4,
    parameter bit              IS_Q_FIXED = 1'b0,
    parameter logic [LOGQ-1:0] Q          = 64'd18446744069414584321,
    parameter int unsigned     SW         = $clog2(MAX_SHIFT + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  q_load,
    input  logic [LOGQ-1:0]       q_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  intt,
    input  logic [SW-1:0]         shift,
    input  logic [LANES*LOGQ-1:0] x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LANES*LOGQ-1:0] y,
    output logic                  busy
);

    localparam int unsigned     DW   = LANES * LOGQ;
    localparam logic [SW-1:0]   KMax = SW'(MAX_SHIFT);
    localparam logic [LOGQ-1:0] One  = LOGQ'(1);

    // Modulus and its precomputed half-plus-one h = (q+1)/2.
    logic [LOGQ-1:0] q_q;
    logic [LOGQ-1:0] h_q;

    // Per-stage valid, data and effective shift of the beat held there.
    logic [MAX_SHIFT-1:0] v_q;
    logic [DW-1:0]        d_q   [MAX_SHIFT];
    logic [SW-1:0]        k_q   [MAX_SHIFT];

    logic [MAX_SHIFT-1:0] cap;
    logic [MAX_SHIFT-1:0] nxt_v;
    logic [DW-1:0]        nxt_d [MAX_SHIFT];
    logic [SW-1:0]        nxt_k [MAX_SHIFT];

    logic          in_fire;
    logic          q_we;
    logic [SW-1:0] ke_in;

    // Halve every lane modulo q: odd v maps to (v >> 1) + h = (v + q) / 2,
    // which stays below q, so no carry-out is needed.
    function automatic logic [DW-1:0] halve(input logic [DW-1:0] v,
                                            input logic [LOGQ-1:0] h);
        logic [LOGQ-1:0] lane;
        halve = '0;
        for (int i = 0; i < LANES; i++) begin
            lane = v[i*LOGQ +: LOGQ];
            halve[i*LOGQ +: LOGQ] = lane[0] ? (lane >> 1) + h : (lane >> 1);
        end
    endfunction

    always_comb begin
        ke_in = '0;
        if (intt) begin
            ke_in = (shift > KMax) ? KMax : shift;
        end
    end

    // A stage may capture when it is empty or its content moves on this cycle.
    // Walking from the output back lets empty stages absorb bubbles while the
    // output is stalled.
    always_comb begin : flow
        logic down;
        cap  = '0;
        down = out_ready;
        for (int s = MAX_SHIFT - 1; s >= 0; s--) begin
            cap[s] = !v_q[s] || down;
            down   = cap[s];
        end
    end

    assign in_ready  = !q_load && cap[0];
    assign in_fire   = in_valid && in_ready;
    assign busy      = |v_q;
    assign out_valid = v_q[MAX_SHIFT-1];
    assign y         = d_q[MAX_SHIFT-1];

    for (genvar s = 0; s < MAX_SHIFT; s++) begin : g_stage
        if (s == 0) begin : g_first
            always_comb begin
                nxt_v[0] = in_fire;
                nxt_k[0] = ke_in;
                nxt_d[0] = (ke_in != '0) ? halve(x, h_q) : x;
            end
        end else begin : g_next
            // Stage s+1 (1-based) halves when its position is within the beat's shift.
            always_comb begin
                nxt_v[s] = v_q[s-1];
                nxt_k[s] = k_q[s-1];
                nxt_d[s] = (k_q[s-1] >= SW'(s + 1)) ? halve(d_q[s-1], h_q) : d_q[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_q <= '0;
            for (int s = 0; s < MAX_SHIFT; s++) begin
                d_q[s] <= '0;
                k_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < MAX_SHIFT; s++) begin
                if (cap[s]) begin
                    v_q[s] <= nxt_v[s];
                    if (nxt_v[s]) begin
                        d_q[s] <= nxt_d[s];
                        k_q[s] <= nxt_k[s];
                    end
                end
            end
        end
    end

    // Loading only while idle keeps every in-flight beat on a single modulus.
    assign q_we = !IS_Q_FIXED && q_load && !busy && !in_fire;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q_q <= Q;
            h_q <= (Q >> 1) + One;
        end else if (q_we) begin
            q_q <= q_in;
            h_q <= (q_in >> 1) + One;
        end
    end

    // The modulus itself is kept for visibility; the datapath only needs h.
    logic unused_q;
    assign unused_q = ^q_q;

endmodule

// File: tb/tb_moddiv_pow2_pipe.sv
module tb_moddiv_pow2_pipe;

    localparam logic [63:0] QD = 64'd18446744069414584321;
    localparam logic [63:0] HD = 64'd9223372034707292161;

    logic         clk;
    logic         rstn;
    logic         q_load;
    logic [63:0]  q_in;
    logic         in_valid;
    logic         in_ready;
    logic         intt;
    logic [2:0]   shift;
    logic [127:0] x;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] y;
    logic         busy;

    int n_pass  = 0;
    int n_total = 0;

    moddiv_pow2_pipe dut (
        .clk       (clk),
        .rstn      (rstn),
        .q_load    (q_load),
        .q_in      (q_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .intt      (intt),
        .shift     (shift),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [127:0] lanes(input logic [63:0] a0, input logic [63:0] a1);
        return {a1, a0};
    endfunction

    // Reference: repeated (v + q) / 2 on odd values with a wide intermediate.
    function automatic logic [63:0] model(input logic [63:0] v, input logic [63:0] q,
                                          input logic it, input logic [2:0] sh);
        logic [64:0] t;
        int k;
        k = it ? ((sh > 3'd4) ? 4 : int'(sh)) : 0;
        t = {1'b0, v};
        for (int i = 0; i < k; i++) begin
            if (t[0]) t = (t + {1'b0, q}) >> 1;
            else      t = t >> 1;
        end
        return t[63:0];
    endfunction

    task automatic apply_reset();
        rstn      = 1'b0;
        q_load    = 1'b0;
        q_in      = '0;
        in_valid  = 1'b0;
        intt      = 1'b0;
        shift     = '0;
        x         = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // Offer one beat, then report its result and cycles from acceptance to out_valid.
    task automatic run_beat(input logic it, input logic [2:0] sh,
                            input logic [63:0] a0, input logic [63:0] a1,
                            output logic [63:0] r0, output logic [63:0] r1, output int lat);
        bit ok;
        r0  = 'x;
        r1  = 'x;
        lat = -1;
        ok  = 1'b0;
        @(posedge clk);
        #1;
        intt      = it;
        shift     = sh;
        x         = lanes(a0, a1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        if (ok) begin
            for (int c = 1; c <= 20; c++) begin
                @(negedge clk);
                if (out_valid) begin
                    lat = c;
                    r0  = y[63:0];
                    r1  = y[127:64];
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid);
        else n_pass++;
        n_total++;
        if (y !== 128'd0) $display("FAIL reset_y: got %h want 0", y);
        else n_pass++;
        n_total++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready);
        else n_pass++;
        q_load = 1'b1;
        q_in   = QD;
        #1;
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL qload_blocks_ready: got %b want 0", in_ready);
        else n_pass++;
        q_load = 1'b0;
    endtask

    task automatic test_basic();
        logic [63:0] r0, r1;
        int lat;
        run_beat(1'b1, 3'd1, 64'd1, 64'd4, r0, r1, lat);
        n_total++;
        if (lat !== 4) $display("FAIL shift1_latency: got %0d want 4", lat);
        else n_pass++;
        n_total++;
        if (r0 !== HD) $display("FAIL shift1_lane0: got %0d want %0d", r0, HD);
        else n_pass++;
        n_total++;
        if (r1 !== 64'd2) $display("FAIL shift1_lane1: got %0d want 2", r1);
        else n_pass++;

        run_beat(1'b1, 3'd2, 64'd4, 64'd3, r0, r1, lat);
        n_total++;
        if (r0 !== 64'd1) $display("FAIL shift2_lane0: got %0d want 1", r0);
        else n_pass++;
        n_total++;
        if (r1 !== 64'd4611686017353646081)
            $display("FAIL shift2_lane1: got %0d want 4611686017353646081", r1);
        else n_pass++;

        run_beat(1'b0, 3'd4, 64'd123, QD - 64'd1, r0, r1, lat);
        n_total++;
        if (r0 !== 64'd123) $display("FAIL passthru_lane0: got %0d want 123", r0);
        else n_pass++;
        n_total++;
        if (r1 !== 64'd18446744069414584320)
            $display("FAIL passthru_lane1: got %0d want 18446744069414584320", r1);
        else n_pass++;
        n_total++;
        if (lat !== 4) $display("FAIL passthru_latency: got %0d want 4", lat);
        else n_pass++;

        run_beat(1'b1, 3'd7, 64'd16, 64'd0, r0, r1, lat);
        n_total++;
        if (r0 !== 64'd1) $display("FAIL saturate_lane0: got %0d want 1", r0);
        else n_pass++;
        n_total++;
        if (r1 !== 64'd0) $display("FAIL saturate_lane1: got %0d want 0", r1);
        else n_pass++;
    endtask

    task automatic test_runtime_q();
        logic [63:0] r0, r1;
        int lat;
        bit seen;
        // Load q=7 with a competing beat: the load wins, the beat is not taken.
        @(posedge clk);
        #1;
        q_load   = 1'b1;
        q_in     = 64'd7;
        in_valid = 1'b1;
        x        = lanes(64'd5, 64'd5);
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b0) $display("FAIL load_wins_ready: got %b want 0", in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        q_load   = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b0) $display("FAIL load_wins_no_beat: got busy %b want 0", busy);
        else n_pass++;

        run_beat(1'b1, 3'd2, 64'd1, 64'd6, r0, r1, lat);
        n_total++;
        if (r0 !== 64'd2) $display("FAIL q7_lane0: got %0d want 2", r0);
        else n_pass++;
        n_total++;
        if (r1 !== 64'd5) $display("FAIL q7_lane1: got %0d want 5", r1);
        else n_pass++;

        // Attempt a load of q=11 while a beat is in flight; it must be ignored.
        @(posedge clk);
        #1;
        intt      = 1'b1;
        shift     = 3'd1;
        x         = lanes(64'd1, 64'd1);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        q_load   = 1'b1;
        q_in     = 64'd11;
        @(negedge clk);
        n_total++;
        if (busy !== 1'b1 || in_ready !== 1'b0)
            $display("FAIL busy_load_state: got busy %b ready %b want 1 0", busy, in_ready);
        else n_pass++;
        @(posedge clk);
        #1 q_load = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                n_total++;
                if (y[63:0] !== 64'd4) $display("FAIL busy_load_inflight: got %0d want 4", y[63:0]);
                else n_pass++;
            end
        end
        if (!seen) begin
            n_total++;
            $display("FAIL busy_load_inflight: got no output want 4");
        end

        run_beat(1'b1, 3'd1, 64'd1, 64'd2, r0, r1, lat);
        n_total++;
        if (r0 !== 64'd4 || r1 !== 64'd1)
            $display("FAIL busy_load_ignored: got %0d %0d want 4 1", r0, r1);
        else n_pass++;

        apply_reset();
    endtask

    task automatic test_back_to_back();
        int acc;
        int got;
        acc       = 0;
        out_ready = 1'b0;
        intt      = 1'b0;
        shift     = '0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            x        = lanes(64'(i), 64'(100 + i));
            @(negedge clk);
            if (in_ready) acc++;
        end
        n_total++;
        if (acc !== 4) $display("FAIL full_accepted: got %0d want 4", acc);
        else n_pass++;
        n_total++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || y[63:0] !== 64'd0)
            $display("FAIL full_hold: got ready %b valid %b y0 %0d want 0 1 0",
                     in_ready, out_valid, y[63:0]);
        else n_pass++;

        @(posedge clk);
        #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        x         = lanes(64'd4, 64'd104);
        @(negedge clk);
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL drain_and_accept: got ready %b want 1", in_ready);
        else n_pass++;
        got = 0;
        if (out_valid) begin
            n_total++;
            if (y !== lanes(64'd0, 64'd100)) $display("FAIL drain_order0: got %h want beat 0", y);
            else n_pass++;
            got = 1;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int c = 0; c < 20 && got < 5; c++) begin
            @(negedge clk);
            if (out_valid) begin
                n_total++;
                if (y !== lanes(64'(got), 64'(100 + got)))
                    $display("FAIL drain_order: got %h want beat %0d", y, got);
                else n_pass++;
                got++;
            end
        end
        n_total++;
        if (got !== 5) $display("FAIL drain_count: got %0d want 5", got);
        else n_pass++;
    endtask

    task automatic test_stream();
        logic [127:0] exp_q[$];
        logic [127:0] e;
        logic [63:0]  c0, c1;
        logic         c_it;
        logic [2:0]   c_sh;
        bit           have;
        int           sent, got, cyc;
        sent = 0;
        got  = 0;
        cyc  = 0;
        have = 1'b0;
        c0   = '0;
        c1   = '0;
        c_it = 1'b0;
        c_sh = '0;
        while (got < 32 && cyc < 3000) begin
            @(posedge clk);
            #1;
            if (!have) begin
                c0   = {$urandom(), $urandom()} % QD;
                c1   = {$urandom(), $urandom()} % QD;
                c_it = 1'($urandom_range(0, 1));
                c_sh = 3'($urandom_range(0, 7));
                have = 1'b1;
            end
            intt      = c_it;
            shift     = c_sh;
            x         = lanes(c0, c1);
            in_valid  = (sent < 32) && ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 1) == 1);
            @(negedge clk);
            if (in_valid && in_ready) begin
                exp_q.push_back(lanes(model(c0, QD, c_it, c_sh), model(c1, QD, c_it, c_sh)));
                sent++;
                have = 1'b0;
            end
            if (out_valid && out_ready) begin
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL stream_extra: got %h want no beat", y);
                end else begin
                    e = exp_q.pop_front();
                    if (y !== e) $display("FAIL stream_beat%0d: got %h want %h", got, y, e);
                    else n_pass++;
                end
                got++;
            end
            cyc++;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        n_total++;
        if (got !== 32 || exp_q.size() != 0)
            $display("FAIL stream_count: got %0d left %0d want 32 0", got, exp_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [63:0] r0, r1;
        int lat;
        int spurious;
        out_ready = 1'b0;
        intt      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            in_valid = 1'b1;
            x        = lanes(64'(50 + i), 64'(60 + i));
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_total++;
        if (out_valid !== 1'b1) $display("FAIL premid_valid: got %b want 1", out_valid);
        else n_pass++;
        #2 rstn = 1'b0;
        #1;
        n_total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || y !== 128'd0)
            $display("FAIL midreset_clear: got valid %b busy %b y %h want 0 0 0",
                     out_valid, busy, y);
        else n_pass++;
        @(posedge clk);
        #1;
        rstn      = 1'b1;
        out_ready = 1'b1;
        spurious  = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        n_total++;
        if (spurious !== 0) $display("FAIL midreset_stale: got %0d outputs want 0", spurious);
        else n_pass++;
        run_beat(1'b0, 3'd0, 64'd77, 64'd78, r0, r1, lat);
        n_total++;
        if (r0 !== 64'd77 || r1 !== 64'd78 || lat !== 4)
            $display("FAIL midreset_new: got %0d %0d lat %0d want 77 78 4", r0, r1, lat);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_runtime_q();
        test_back_to_back();
        test_stream();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/moddiv_pow2_pipe.md
# moddiv_pow2_pipe

Multi-lane, pipelined modular halving unit: computes y = x · 2^-k mod q for a per-transaction shift k in 0..MAX_SHIFT, using one halving stage per pipeline register. It sits at the output of the INTT datapath and applies the final n^-1 scaling, or pass-through in forward NTT. It supports any odd modulus, not only q ≡ 1 mod 4. The modulus is either fixed at build time or loaded at run time. A valid/ready handshake with back-pressure and bubble collapsing lets it drop into the streaming butterfly chain.

## Interface
- LOGQ, 64: coefficient and modulus width.
- LANES, 2: parallel coefficients per beat. All lanes share q, shift and intt.
- MAX_SHIFT, 4: number of halving stages; this is also the latency.
- IS_Q_FIXED, 0: 1 ties the modulus to Q and ignores q_load.
- Q, 64'd18446744069414584321: fixed modulus and reset value of the modulus register. Must be odd.
- SW, $clog2(MAX_SHIFT+1): width of shift.

- clk  in  1  rising-edge clock.
- rstn  in  1  reset, asynchronous, active-low.
- q_load  in  1  load q_in into the modulus register.
- q_in  in  LOGQ  new modulus; must be odd.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid && in_ready.
- intt  in  1  1 = divide by 2^shift; 0 = pass x unchanged. Sampled with the beat.
- shift  in  SW  k, sampled with the beat.
- x  in  LANES*LOGQ  lane i = x[i*LOGQ +: LOGQ]; each lane < q.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- y  out  LANES*LOGQ  results, lane order preserved.
- busy  out  1  at least one stage holds a valid beat.

## Operation
- Effective shift: ke = min(shift, MAX_SHIFT) if intt=1, else 0. A shift above MAX_SHIFT saturates silently.
- Stage s (1..MAX_SHIFT) registers data, valid, ke and a stage counter. A stage halves when s ≤ ke and passes the value through otherwise.
- Halving of value v (0 ≤ v < q), computed per lane:
  - v even: v >> 1.
  - v odd: (v >> 1) + h, where h = (q >> 1) + 1 = (q+1)/2.
  - Result is < q and fits LOGQ bits, so no carry-out is needed.
  - h is precomputed and registered at q load, exact for any odd q.
- Modulus register:
  - Reset value Q.
  - When IS_Q_FIXED=0, q_load && !busy && !in_valid_fire loads q_in. The new value is usable by the next accepted beat.
  - q_load while busy is ignored; the register keeps its value.
  - While q_load=1, in_ready=0.
- Flow control: stage s may capture when it is empty or its content advances this cycle. Beats never duplicate, drop or reorder.
- Bubble collapsing: an empty stage accepts from upstream even when the output is stalled.
- in_ready = !q_load && (stage1 empty || stage1 advances).
- Output: y and out_valid come from the last stage register. y holds stable while out_valid && !out_ready.
- Out-of-range x (≥ q) is undefined but must not hang the pipe.

## Timing
- Latency: exactly MAX_SHIFT cycles from acceptance to out_valid with no stalls. Throughput is 1 beat/cycle.
- Reset (rstn=0, asynchronous): all stage valids 0, all data 0, out_valid=0, y=0, busy=0, modulus register = Q, h = (Q+1)/2. in_ready=1 once q_load=0.
- Reset mid-stream: in-flight beats are discarded. No output appears until a new beat is accepted after rstn rises.
- Full pipe with out_ready=0: MAX_SHIFT beats held, in_ready=0.
- Simultaneous out_ready=1 with in_valid=1: the pipe both drains and accepts in the same cycle, so in_ready stays 1.
- q_load and in_valid in the same cycle: the load wins and the beat is not accepted.

## Test plan
- Default Q, LANES=2, shift=1, intt=1, x = {1, 4} → y = {9223372034707292161, 2} after 4 cycles.
- shift=2, x = {4, 3}:
  - lane 0: 4 → 2 → 1, so y lane 0 = 1.
  - lane 1: 3 → (3+Q)/2 = 9223372034707292162 → 4611686017353646081, so y lane 1 = 4611686017353646081.
- intt=0, shift=4, x = {123, Q-1} → y = {123, Q-1}.
- Saturation: shift=7, x = {16, 0} → y = {1, 0}.
- Run-time modulus (q ≡ 3 mod 4): q_load with q_in=7 while idle, then shift=2, x = {1, 6} → y = {2, 5}.
  - 1·4^-1 mod 7 = 2; 6·2 mod 7 = 5.
  - A q_load issued while busy leaves q unchanged.
- Streaming and back-pressure:
  - Send 32 random beats with random in_valid and out_ready at 50% duty. Outputs must match the model in order with none lost.
  - Assert rstn=0 mid-stream: out_valid drops in the same cycle, and only post-reset beats emerge afterwards.
